control_unit_mc: RTL

Multicycle control unit for the RV32I core. It sits directly upstream of the multicycle datapath. It consumes the decode fields the datapath exports (`op`, `f3`, `f7`, `zero`) and drives every datapath select and write-enable, one micro-step per clock. A Moore main FSM sequences each instruction through fetch/decode/execute/memory/writeback; combinational ALU and immediate decoders complete the control word.

---
 rtl/uc_pkg.sv | 59 +++++
 rtl/control_unit_mc_alu_decoder.sv | 29 ++
 rtl/control_unit_mc.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/uc_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
// UC_ILLEGAL_TRAP_EN adds the HALT state used by the illegal-opcode trap.
package uc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_JAL,
        S_BEQ
`ifdef UC_ILLEGAL_TRAP_EN
        ,
        S_HALT
`endif
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [1:0] {
        AOP_ADD   = 2'b00,
        AOP_SUB   = 2'b01,
        AOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/control_unit_mc_alu_decoder.sv
// ALU operation decoder: maps aluOp plus funct fields to an ALUControl code.
module alu_decoder
    import uc_pkg::*;
(
    input  aluop_t      alu_op,
    input  logic [2:0]  f3,
    input  logic        op5,
    input  logic        f7,
    output logic [2:0]  alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            AOP_SUB: alu_control = ALU_SUB;
            AOP_FUNCT: begin
                case (f3)
                    3'b000:  alu_control = (op5 & f7) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control_unit_mc.sv
// Multicycle RV32I control unit: Moore main FSM plus ALU/immediate decode.
// Defining UC_ILLEGAL_TRAP_EN adds the HALT state and the illegal output.
module control_unit_mc
    import uc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  op,
    input  logic [2:0]  f3,
    input  logic        f7,
    input  logic        zero,
    output logic        pcWrite,
    output logic        adrSrc,
    output logic        memWrite,
    output logic        irWrite,
    output logic [1:0]  resultSrc,
    output logic [1:0]  aluSrcA,
    output logic [1:0]  aluSrcB,
    output logic [2:0]  ALUControl,
    output logic [1:0]  inmSrc,
    output logic        regWrite
`ifdef UC_ILLEGAL_TRAP_EN
    ,
    output logic        illegal
`endif
);

    state_t state, next_state;
    aluop_t alu_op;
    logic   pc_update, branch;
    logic   ir_en, mem_en, reg_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= next_state;
    end

    always_comb begin
        next_state = S_FETCH;
        alu_op     = AOP_ADD;
        pc_update  = 1'b0;
        branch     = 1'b0;
        ir_en      = 1'b0;
        mem_en     = 1'b0;
        reg_en     = 1'b0;
        adrSrc     = 1'b0;
        resultSrc  = RES_ALUOUT;
        aluSrcA    = SRCA_PC;
        aluSrcB    = SRCB_RD2;
        unique case (state)
            S_FETCH: begin
                ir_en      = 1'b1;
                pc_update  = 1'b1;
                aluSrcB    = SRCB_FOUR;
                resultSrc  = RES_ALURESULT;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                aluSrcA = SRCA_OLDPC;
                aluSrcB = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_RTYPE:          next_state = S_EXECUTER;
                    OP_ITYPE:          next_state = S_EXECUTEI;
                    OP_JAL:            next_state = S_JAL;
                    OP_BRANCH:         next_state = S_BEQ;
`ifdef UC_ILLEGAL_TRAP_EN
                    default:           next_state = S_HALT;
`else
                    default:           next_state = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                aluSrcA    = SRCA_RD1;
                aluSrcB    = SRCB_IMM;
                next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adrSrc     = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                resultSrc = RES_DATA;
                reg_en    = 1'b1;
            end
            S_MEMWRITE: begin
                adrSrc = 1'b1;
                mem_en = 1'b1;
            end
            S_EXECUTER: begin
                aluSrcA    = SRCA_RD1;
                alu_op     = AOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_EXECUTEI: begin
                aluSrcA    = SRCA_RD1;
                aluSrcB    = SRCB_IMM;
                alu_op     = AOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_ALUWB: reg_en = 1'b1;
            S_JAL: begin
                aluSrcA    = SRCA_OLDPC;
                aluSrcB    = SRCB_FOUR;
                pc_update  = 1'b1;
                next_state = S_ALUWB;
            end
            S_BEQ: begin
                aluSrcA = SRCA_RD1;
                alu_op  = AOP_SUB;
                branch  = 1'b1;
            end
`ifdef UC_ILLEGAL_TRAP_EN
            S_HALT: next_state = S_HALT;
`endif
            default: next_state = S_FETCH;
        endcase
    end

    // Reset gates the enables combinationally so nothing writes once it asserts.
    assign pcWrite  = rst_n & (pc_update | (branch & zero));
    assign irWrite  = rst_n & ir_en;
    assign memWrite = rst_n & mem_en;
    assign regWrite = rst_n & reg_en;

`ifdef UC_ILLEGAL_TRAP_EN
    assign illegal = (state == S_HALT);
`endif

    always_comb begin
        inmSrc = IMM_I;
        case (op)
            OP_STORE:  inmSrc = IMM_S;
            OP_BRANCH: inmSrc = IMM_B;
            OP_JAL:    inmSrc = IMM_J;
            default:   inmSrc = IMM_I;
        endcase
    end

    alu_decoder u_alu_dec (
        .alu_op      (alu_op),
        .f3          (f3),
        .op5         (op[5]),
        .f7          (f7),
        .alu_control (ALUControl)
    );

endmodule
